// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, frame width and baud divisor helper for the UART core.
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // RX_BREAK holds off re-arming after a framing error until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: two-flop synchronizer and mid-bit sampling receive FSM.
// Even parity check is compiled in when UART_PARITY_EN is defined.
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic sync1_q, sync2_q, line_prev_q;
  logic line, fall;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
  logic                 frame_ok;

  assign line = sync2_q;
  assign fall = line_prev_q & ~sync2_q;

`ifdef UART_PARITY_EN
  logic par_err_q, par_err_d;
  assign frame_ok = line & ~par_err_q;
`else
  assign frame_ok = line;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    error_d = error_q;
`ifdef UART_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) begin
          state_d = RX_START;
          ready_d = 1'b0;
          error_d = 1'b0;
        end
      end
      RX_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_err_d = line ^ (^shift_q);
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (frame_ok) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = line ? RX_IDLE : RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (line) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx_serial;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
`ifdef UART_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign rx_data  = data_q;
  assign rx_ready = ready_q;
  assign rx_error = error_q;

endmodule

`default_nettype wire

// File: rtl/uart_top.sv
// uart_top: full-duplex UART, inline TX FSM plus uart_rx receiver sharing one baud divisor.
// Define UART_PARITY_EN for an even parity bit after D7 (11-bit frame); default is 8N1.
`default_nettype none

module uart_top
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_error
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_done_q, tx_done_d;
  logic                 bit_end;

  assign bit_end = (tx_cnt_q == CNT_LAST);

  // tx_serial is registered so each bit starts exactly on a state transition.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_data_d   = tx_data_q;
    tx_serial_d = tx_serial_q;
    tx_done_d   = 1'b0;
    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = bit_end ? '0 : tx_cnt_q + 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        tx_serial_d = 1'b1;
        if (tx_start) begin
          tx_state_d  = TX_START;
          tx_data_d   = tx_data;
          tx_cnt_d    = '0;
          tx_bit_d    = '0;
          tx_serial_d = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          tx_state_d  = TX_DATA;
          tx_serial_d = tx_data_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d  = TX_PARITY;
            tx_serial_d = ^tx_data_q;
`else
            tx_state_d  = TX_STOP;
            tx_serial_d = 1'b1;
`endif
          end else begin
            tx_bit_d    = tx_bit_q + 1'b1;
            tx_serial_d = tx_data_q[tx_bit_d];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          tx_state_d  = TX_STOP;
          tx_serial_d = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        tx_serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_data_q   <= '0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_data_q   <= tx_data_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign tx_done   = tx_done_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_error (rx_error)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_top.sv
// tb_uart_top: loopback bench with a TX line decoder and an RX scoreboard fed by the stimulus.
`default_nettype none

module tb_uart_top;

  localparam int CF  = 1_000_000;
  localparam int BR  = 10_000;
  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_serial, tx_busy, tx_done;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_ready, rx_error;
  logic       rx_force_low = 1'b0;

  assign rx_serial = tx_serial & ~rx_force_low;

  always #5 clk = ~clk;

  uart_top #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_error (rx_error)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RX scoreboard: each new rx_ready or rx_error level pops one expected entry.
  logic    mon_pr = 1'b0;
  logic    mon_pe = 1'b0;
  rx_exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && rx_ready && !mon_pr) begin
        if (rx_q.size() == 0) check("rx_unexpected_ready", 32'd1, 32'd0);
        else begin
          mon_e = rx_q.pop_front();
          check("rx_ready_vs_expected_err", {31'd0, mon_e.err}, 32'd0);
          check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
          check("rx_error_with_ready", {31'd0, rx_error}, 32'd0);
        end
      end
      if (rst && rx_error && !mon_pe) begin
        if (rx_q.size() == 0) check("rx_unexpected_error", 32'd1, 32'd0);
        else begin
          mon_e = rx_q.pop_front();
          check("rx_error_vs_expected_err", {31'd0, mon_e.err}, 32'd1);
          check("rx_data_kept", {24'd0, rx_data}, {24'd0, mon_e.data});
          check("rx_ready_with_error", {31'd0, rx_ready}, 32'd0);
        end
      end
      mon_pr = rx_ready;
      mon_pe = rx_error;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_done) begin
        done_cnt++;
        check("tx_busy_at_done", {31'd0, tx_busy}, 32'd0);
      end
    end
  end

  // TX line decoder: samples mid-bit, abandons any frame that sees reset.
  logic       dec_prev = 1'b1;
  logic [7:0] dec_b;
  logic       dec_ab, dec_startb, dec_stopb;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && dec_prev && !tx_serial) begin
        dec_ab = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        if (!rst) dec_ab = 1'b1;
        dec_startb = tx_serial;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          if (!rst) dec_ab = 1'b1;
          dec_b[i] = tx_serial;
        end
        repeat (CPB) @(negedge clk);
        if (!rst) dec_ab = 1'b1;
        dec_stopb = tx_serial;
        if (!dec_ab) begin
          check("tx_start_bit", {31'd0, dec_startb}, 32'd0);
          check("tx_stop_bit", {31'd0, dec_stopb}, 32'd1);
          if (tx_q.size() == 0) check("tx_unexpected_frame", 32'd1, 32'd0);
          else check("tx_frame_byte", {24'd0, dec_b}, {24'd0, tx_q.pop_front()});
        end
      end
      dec_prev = tx_serial;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (!tx_done && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_timeout"}, {31'd0, (n < 1500)}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    tx_q.push_back(b);
    rx_q.push_back('{err: 1'b0, data: b});
    @(negedge clk);
    tx_start = 1'b0;
    repeat (60) @(negedge clk);
    check("rx_ready_clear_at_start", {31'd0, rx_ready}, 32'd0);
    wait_done("send");
    last_good = b;
  endtask

  int         lat;
  int         lows;
  int         done_before;
  logic [7:0] b2b [4];

  initial begin
    #1 rst = 1'b0;
    #1000;
    @(negedge clk);
    check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_rx_error", {31'd0, rx_error}, 32'd0);
    rst = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx_serial || tx_busy) lows++;
    end
    check("idle_line_constant_high", lows, 32'd0);

    // Single byte, tx_start held two cycles; done must land 1000 clocks after acceptance.
    tx_data  = 8'h08;
    tx_start = 1'b1;
    tx_q.push_back(8'h08);
    rx_q.push_back('{err: 1'b0, data: 8'h08});
    @(negedge clk);
    check("busy_after_accept", {31'd0, tx_busy}, 32'd1);
    check("start_bit_driven", {31'd0, tx_serial}, 32'd0);
    lat = 0;
    @(negedge clk);
    tx_start = 1'b0;
    lat = 1;
    while (!tx_done && lat < 1200) begin
      @(negedge clk);
      lat++;
    end
    check("tx_done_latency", lat, 32'd1000);
    check("rx_ready_at_done", {31'd0, rx_ready}, 32'd1);
    check("rx_data_at_done", {24'd0, rx_data}, 32'h08);
    last_good = 8'h08;
    repeat (20) @(negedge clk);
    check("rx_ready_held_past_done", {31'd0, rx_ready}, 32'd1);

    b2b = '{8'h31, 8'h69, 8'h23, 8'hBB};
    for (int i = 0; i < 4; i++) begin
      repeat (500) @(negedge clk);
      send(b2b[i]);
    end

    // A second tx_start mid-frame must neither alter the frame nor add a tx_done.
    repeat (500) @(negedge clk);
    done_before = done_cnt;
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    tx_q.push_back(8'hC3);
    rx_q.push_back('{err: 1'b0, data: 8'hC3});
    @(negedge clk);
    tx_start = 1'b0;
    repeat (200) @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("ignored_start");
    last_good = 8'hC3;
    repeat (50) @(negedge clk);
    check("single_tx_done", done_cnt - done_before, 32'd1);
    check("rx_after_ignored_start", {24'd0, rx_data}, 32'hC3);

    // Line held low through the stop bit.
    repeat (300) @(negedge clk);
    rx_q.push_back('{err: 1'b1, data: last_good});
    rx_force_low = 1'b1;
    repeat (1200) @(negedge clk);
    check("break_rx_error", {31'd0, rx_error}, 32'd1);
    check("break_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("break_rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
    rx_force_low = 1'b0;
    repeat (200) @(negedge clk);

    // Short glitch: false start, flags cleared by the falling edge, no new error.
    rx_force_low = 1'b1;
    repeat (20) @(negedge clk);
    rx_force_low = 1'b0;
    repeat (1200) @(negedge clk);
    check("glitch_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("glitch_rx_error", {31'd0, rx_error}, 32'd0);

    // Reset mid-frame.
    tx_data  = 8'hE7;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx_serial", {31'd0, tx_serial}, 32'd1);
    check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    repeat (1000) @(negedge clk);
    check("post_rst_idle_busy", {31'd0, tx_busy}, 32'd0);
    send(8'h5A);
    repeat (200) @(negedge clk);

    check("rx_queue_drained", rx_q.size(), 32'd0);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
